feistel_engine: RTL and testbench

Parametrised Blowfish/bcrypt Feistel round engine. It encrypts or decrypts one 64-bit block (L,R) per transaction against an external P-array and an external synchronous S-box memory of configurable read latency, with an optional pre-whitening XOR for the salt step of EksBlowfish expansion. It sits between the key-schedule controller, which owns the P/S storage and sequencing, and the P/S write-back path, which consumes out_l/out_r.

---
 rtl/feistel_engine.sv | 99 +++++++++
 tb/tb_feistel_engine.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/feistel_engine.sv
// feistel_engine: Blowfish/bcrypt Feistel round engine with external P-array and latency-configurable S-boxes
module feistel_engine #(
  parameter int ROUNDS   = 16,
  parameter int SBOX_LAT = 1,
  parameter int PIDX_W   = $clog2(ROUNDS + 2)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_decrypt,
  input  logic [31:0]       in_l,
  input  logic [31:0]       in_r,
  input  logic [31:0]       in_xl,
  input  logic [31:0]       in_xr,
  output logic [PIDX_W-1:0] p_idx,
  input  logic [31:0]       p_data,
  output logic              sbox_re,
  output logic [7:0]        sbox_addr0,
  output logic [7:0]        sbox_addr1,
  output logic [7:0]        sbox_addr2,
  output logic [7:0]        sbox_addr3,
  input  logic [31:0]       sbox_data0,
  input  logic [31:0]       sbox_data1,
  input  logic [31:0]       sbox_data2,
  input  logic [31:0]       sbox_data3,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [31:0]       out_l,
  output logic [31:0]       out_r,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, XORP, LOOK, FIN0, FIN1, DONE} state_t;
  localparam logic [PIDX_W-1:0] PLAST = PIDX_W'(ROUNDS + 1);
  localparam logic [PIDX_W-1:0] PFIN  = PIDX_W'(ROUNDS);
  localparam logic [PIDX_W-1:0] RLAST = PIDX_W'(ROUNDS - 1);
  localparam logic [1:0]        WLAST = 2'(SBOX_LAT - 1);
  state_t state;
  logic [31:0] l, r, f;
  logic dec;
  logic [PIDX_W-1:0] rnd;
  logic [1:0] wcnt;
  logic look;
  assign look = state == LOOK;
  assign f = ((sbox_data0 + sbox_data1) ^ sbox_data2) + sbox_data3;
  assign in_ready = state == IDLE;
  assign busy = state != IDLE;
  assign out_valid = state == DONE;
  assign out_l = out_valid ? l : '0;
  assign out_r = out_valid ? r : '0;
  assign sbox_re = look && wcnt == 2'd0;
  assign {sbox_addr0, sbox_addr1, sbox_addr2, sbox_addr3} = look ? l : '0;
  // P index selects forward or reversed order; idle/lookup/done states drive 0
  always_comb
    p_idx = state == XORP ? (dec ? PLAST - rnd : rnd) :
            state == FIN0 ? (dec ? PIDX_W'(1) : PFIN) :
            state == FIN1 ? (dec ? '0 : PLAST) : '0;
  // round sequencer: whiten, wait for S-box data, mix and swap, then final untwist
  always_ff @(posedge clk)
    if (reset) begin
      state <= IDLE;
      l     <= '0;
      r     <= '0;
      dec   <= 1'b0;
      rnd   <= '0;
      wcnt  <= '0;
    end else
      case (state)
        IDLE: if (in_valid) begin
          l     <= in_l ^ in_xl;
          r     <= in_r ^ in_xr;
          dec   <= in_decrypt;
          rnd   <= '0;
          state <= XORP;
        end
        XORP: begin
          l     <= l ^ p_data;
          wcnt  <= '0;
          state <= LOOK;
        end
        LOOK: if (wcnt == WLAST) begin
          l     <= r ^ f;
          r     <= l;
          rnd   <= rnd + PIDX_W'(1);
          state <= rnd == RLAST ? FIN0 : XORP;
        end else wcnt <= wcnt + 2'd1;
        FIN0: begin
          l     <= r;
          r     <= l ^ p_data;
          state <= FIN1;
        end
        FIN1: begin
          l     <= l ^ p_data;
          state <= DONE;
        end
        DONE: if (out_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
endmodule

// File: tb/tb_feistel_engine.sv
// tb_feistel_engine: checks two engines (S-box latency 1 and 2) against a textbook Blowfish model
module tb_feistel_engine;
  localparam int R = 16;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_decrypt = 1'b0;
  logic [31:0] in_l = '0, in_r = '0, in_xl = '0, in_xr = '0;
  logic in_valid [2];
  logic out_ready [2];
  logic in_ready [2], out_valid [2], busy [2], sbox_re [2];
  logic [4:0] p_idx [2];
  logic [31:0] p_data [2], out_l [2], out_r [2];
  logic [7:0] a0 [2], a1 [2], a2 [2], a3 [2];
  logic [31:0] d0 [2], d1 [2], d2 [2], d3 [2];
  logic [31:0] pa [32];
  logic [31:0] sb [4][256];
  int re_cnt [2];
  int ncmp = 0, nerr = 0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : gi
    feistel_engine #(.ROUNDS(R), .SBOX_LAT(g + 1)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid[g]), .in_ready(in_ready[g]),
      .in_decrypt(in_decrypt), .in_l(in_l), .in_r(in_r), .in_xl(in_xl), .in_xr(in_xr),
      .p_idx(p_idx[g]), .p_data(p_data[g]), .sbox_re(sbox_re[g]),
      .sbox_addr0(a0[g]), .sbox_addr1(a1[g]), .sbox_addr2(a2[g]), .sbox_addr3(a3[g]),
      .sbox_data0(d0[g]), .sbox_data1(d1[g]), .sbox_data2(d2[g]), .sbox_data3(d3[g]),
      .out_valid(out_valid[g]), .out_ready(out_ready[g]), .out_l(out_l[g]), .out_r(out_r[g]),
      .busy(busy[g]));
    assign p_data[g] = pa[p_idx[g]];
    assign d0[g] = sb[0][a0[g]];
    assign d1[g] = sb[1][a1[g]];
    assign d2[g] = sb[2][a2[g]];
    assign d3[g] = sb[3][a3[g]];
    always @(negedge clk) if (sbox_re[g]) re_cnt[g]++;
  end

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  logic prev_re = 1'b0;
  logic [31:0] cap_addr;
  always @(negedge clk) begin
    if (prev_re) chk("addr_stable", {a0[1], a1[1], a2[1], a3[1]}, cap_addr);
    prev_re = sbox_re[1];
    if (sbox_re[1]) cap_addr = {a0[1], a1[1], a2[1], a3[1]};
  end

  function automatic logic [31:0] ff(input logic [31:0] x);
    return ((sb[0][x[31:24]] + sb[1][x[23:16]]) ^ sb[2][x[15:8]]) + sb[3][x[7:0]];
  endfunction

  function automatic logic [63:0] model(input logic [31:0] l, r, input logic dec);
    logic [31:0] x, y, t;
    x = l;
    y = r;
    for (int i = 0; i < R; i++) begin
      x ^= pa[dec ? R + 1 - i : i];
      y ^= ff(x);
      t = x; x = y; y = t;
    end
    t = x; x = y; y = t;
    y ^= pa[dec ? 1 : R];
    x ^= pa[dec ? 0 : R + 1];
    return {x, y};
  endfunction

  task automatic run(input int g, input logic [31:0] l, r, xl, xr, input logic dec, input int hold,
                     output logic [63:0] res, output int lat, output int pulses);
    int base;
    @(negedge clk);
    chk("ready", in_ready[g], 1);
    in_l = l; in_r = r; in_xl = xl; in_xr = xr; in_decrypt = dec;
    in_valid[g] = 1'b1;
    out_ready[g] = hold == 0;
    base = re_cnt[g];
    @(posedge clk);
    #1 in_valid[g] = 1'b0;
    lat = 0;
    do begin
      @(posedge clk);
      #1 lat++;
    end while (!out_valid[g] && lat < 200);
    chk("no_timeout", lat < 200, 1);
    res = {out_l[g], out_r[g]};
    pulses = re_cnt[g] - base;
    if (hold > 0) begin
      for (int k = 0; k < hold; k++) begin
        @(negedge clk);
        in_valid[g] = k[0];
        in_l = $urandom;
        chk("bp_hold", {in_ready[g], out_valid[g], out_l[g], out_r[g]}, {2'b01, res});
      end
      @(negedge clk);
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
    end
    @(posedge clk);
    #1 chk("retire", {in_ready[g], out_valid[g]}, 2'b10);
  endtask

  typedef struct {
    logic [31:0] l, r, xl, xr;
    logic dec;
    logic [63:0] exp;
  } vec_t;
  vec_t tv [5];

  initial begin
    logic [63:0] res, exp, ct;
    logic [31:0] l, r, xl, xr;
    logic dec;
    int lat, pulses, base;
    for (int g = 0; g < 2; g++) begin
      in_valid[g] = 1'b0;
      out_ready[g] = 1'b1;
      re_cnt[g] = 0;
    end
    for (int i = 0; i < 32; i++) pa[i] = '0;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 256; j++) sb[i][j] = '0;
    tv[0] = '{32'h1, 32'h2, 32'h0, 32'h0, 1'b0, 64'h00000002_00000001};
    tv[1] = '{32'h1, 32'h2, 32'h0, 32'h0, 1'b1, 64'h00000002_00000001};
    tv[2] = '{32'h0, 32'h0, 32'hDEADBEEF, 32'h01234567, 1'b0, 64'h01234567_DEADBEEF};
    tv[3] = '{32'hFFFFFFFF, 32'h0, 32'h0, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFF_FFFFFFFF};
    tv[4] = '{32'hA5A5A5A5, 32'h5A5A5A5A, 32'h0F0F0F0F, 32'hF0F0F0F0, 1'b1, 64'hAAAAAAAA_AAAAAAAA};
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      chk("rst_ctl", {in_ready[g], out_valid[g], busy[g], sbox_re[g], p_idx[g], a0[g], a1[g], a2[g], a3[g]},
          {4'b1000, 5'd0, 32'd0});
      chk("rst_out", {out_l[g], out_r[g]}, 64'd0);
    end
    reset = 1'b0;
    for (int i = 0; i < 5; i++)
      for (int g = 0; g < 2; g++) begin
        run(g, tv[i].l, tv[i].r, tv[i].xl, tv[i].xr, tv[i].dec, 0, res, lat, pulses);
        chk("zero_tab", res, tv[i].exp);
        chk("latency", lat, R * (g + 2) + 2);
        chk("pulses", pulses, R);
      end
    for (int i = 0; i < 18; i++) pa[i] = $urandom;
    for (int i = 0; i < 4; i++) for (int j = 0; j < 256; j++) sb[i][j] = $urandom;
    for (int g = 0; g < 2; g++) begin
      run(g, 32'h0, 32'h0, 32'hDEADBEEF, 32'h01234567, 1'b0, 0, res, lat, pulses);
      chk("prexor", res, model(32'hDEADBEEF, 32'h01234567, 1'b0));
    end
    for (int i = 0; i < 16; i++) begin
      l = $urandom; r = $urandom; xl = i[2] ? $urandom : 0; xr = i[2] ? $urandom : 0;
      dec = i[1];
      exp = model(l ^ xl, r ^ xr, dec);
      run(i % 2, l, r, xl, xr, dec, 0, res, lat, pulses);
      chk("rand", res, exp);
      chk("rand_lat", lat, R * (i % 2 + 2) + 2);
    end
    for (int g = 0; g < 2; g++) begin
      l = $urandom; r = $urandom;
      run(g, l, r, 0, 0, 1'b0, 0, ct, lat, pulses);
      chk("rt_enc", ct, model(l, r, 1'b0));
      run(g, ct[63:32], ct[31:0], 0, 0, 1'b1, 0, res, lat, pulses);
      chk("rt_dec", res, {l, r});
    end
    l = $urandom; r = $urandom;
    run(0, l, r, 0, 0, 1'b0, 10, res, lat, pulses);
    chk("bp_result", res, model(l, r, 1'b0));
    @(negedge clk);
    chk("bp_no_accept", busy[0], 0);
    @(negedge clk);
    in_l = $urandom; in_r = $urandom; in_xl = 0; in_xr = 0; in_decrypt = 1'b0;
    in_valid[0] = 1'b1;
    @(posedge clk);
    #1 in_valid[0] = 1'b0;
    repeat (7 * 2 + 1) @(posedge clk);
    @(negedge clk);
    chk("mid_busy", busy[0], 1);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    chk("abort", {in_ready[0], out_valid[0], busy[0]}, 3'b100);
    base = re_cnt[0];
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("abort_quiet", re_cnt[0] - base, 0);
    l = $urandom; r = $urandom;
    run(0, l, r, 0, 0, 1'b0, 0, res, lat, pulses);
    chk("post_abort", res, model(l, r, 1'b0));
    chk("post_abort_lat", lat, R * 2 + 2);
    chk("post_abort_pulses", pulses, R);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end
endmodule
